// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - state encoding and mode constants for countdown_timer
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_AUTO    = 1'b1;

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with one-shot / auto-reload and tc pulse
module countdown_timer
   import timer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             abort,
   input  logic             en,
   input  logic             mode,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             zero
);

   state_t           state, state_n;
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] reload, reload_n;
   logic             mode_q, mode_n;
   logic             tc_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         reload <= '0;
         mode_q <= MODE_ONESHOT;
         tc     <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         reload <= reload_n;
         mode_q <= mode_n;
         tc     <= tc_n;
         busy   <= (state_n == RUN);
      end
   end

   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload;
      mode_n   = mode_q;
      tc_n     = 1'b0;
      if (load) begin
         reload_n = load_val;
         count_n  = load_val;
         state_n  = IDLE;
      end else if (abort && state != IDLE) begin
         state_n = IDLE;
      end else if (start) begin
         mode_n = mode;
         // A zero reload terminates immediately so auto mode never spins on a zero period.
         if (reload == '0) begin
            count_n = '0;
            tc_n    = 1'b1;
            state_n = DONE;
         end else begin
            count_n = reload;
            state_n = RUN;
         end
      end else if (state == RUN && en) begin
         if (count > WIDTH'(1)) begin
            count_n = count - WIDTH'(1);
         end else if (count == WIDTH'(1)) begin
            tc_n = 1'b1;
            if (mode_q == MODE_AUTO) begin
               count_n = reload;
            end else begin
               count_n = '0;
               state_n = DONE;
            end
         end else begin
            state_n = DONE;
         end
      end
   end

   assign zero = (count == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - randomized and directed self-checking bench for countdown_timer
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'd0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       en = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] count;
   logic       busy;
   logic       tc;
   logic       zero;

   int n_cmp = 0;
   int n_bad = 0;
   bit check_en = 1'b0;

   // Model: phase 0=idle 1=run 2=done; count in run derives from enabled cycles elapsed.
   int m_phase = 0;
   int m_held = 0;
   int m_reload = 0;
   int m_elapsed = 0;
   bit m_auto = 1'b0;
   bit m_tc = 1'b0;

   countdown_timer #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val),
      .start(start), .abort(abort), .en(en), .mode(mode),
      .count(count), .busy(busy), .tc(tc), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic int m_count();
      if (m_phase == 0) return m_held;
      if (m_phase == 2) return 0;
      if (m_auto) return m_reload - (m_elapsed % m_reload);
      return m_reload - m_elapsed;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      m_tc = 1'b0;
      if (rst) begin
         m_phase = 0; m_held = 0; m_reload = 0; m_elapsed = 0; m_auto = 1'b0;
      end else if (load) begin
         m_reload = int'(load_val); m_held = int'(load_val); m_phase = 0;
      end else if (abort && m_phase != 0) begin
         m_held = m_count(); m_phase = 0;
      end else if (start) begin
         m_auto = mode; m_elapsed = 0;
         if (m_reload == 0) begin
            m_phase = 2; m_tc = 1'b1;
         end else begin
            m_phase = 1;
         end
      end else if (m_phase == 1 && en) begin
         m_elapsed++;
         if (m_elapsed % m_reload == 0) m_tc = 1'b1;
         if (!m_auto && m_elapsed == m_reload) m_phase = 2;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_count", int'(count), m_count());
         chk("model_busy", int'(busy), int'(m_phase == 1));
         chk("model_tc", int'(tc), int'(m_tc));
         chk("model_zero", int'(zero), int'(m_count() == 0));
      end
   end

   task automatic step(input logic ld, input logic [7:0] lv, input logic st,
                       input logic ab, input logic e, input logic md);
      load = ld; load_val = lv; start = st; abort = ab; en = e; mode = md;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0; start = 1'b0; abort = 1'b0;
   endtask

   task automatic lit(input string nm, input int c, input int b, input int t);
      chk({nm, "_count"}, int'(count), c);
      chk({nm, "_busy"}, int'(busy), b);
      chk({nm, "_tc"}, int'(tc), t);
      chk({nm, "_zero"}, int'(zero), int'(c == 0));
   endtask

   initial begin
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 8'd9, 1'b1, 1'b0, 1'b1, 1'b1);
      check_en = 1'b1;
      lit("rst1", 0, 0, 0);
      step(1'b0, 8'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      lit("rst2", 0, 0, 0);
      rst = 1'b0;

      step(1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0);
      lit("os_load", 5, 0, 0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      lit("os_start", 5, 1, 0);
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         lit("os_run", 5 - i, int'(i < 5), int'(i == 5));
      end
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      lit("os_done", 0, 0, 0);

      step(1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      lit("ar_start", 3, 1, 0);
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         lit("ar_run", 3 - (i % 3), 1, int'(i % 3 == 0));
      end

      step(1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      lit("pause_dec", 3, 1, 0);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("pause_1", 3, 1, 0);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("pause_2", 3, 1, 0);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      lit("pause_tc", 0, 0, 1);

      step(1'b1, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (4) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      lit("mid_pre", 2, 1, 0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      lit("mid_restart", 6, 1, 0);
      repeat (4) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      lit("mid_abort", 2, 0, 0);
      step(1'b1, 8'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      lit("mid_load_start", 7, 0, 0);

      step(1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      lit("zero_auto", 0, 0, 1);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      lit("zero_after", 0, 0, 0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      lit("zero_os", 0, 0, 1);

      step(1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      lit("rst_run", 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         logic       r_ld, r_st, r_ab, r_en, r_md;
         logic [7:0] r_lv;
         int         op;
         op   = int'($urandom_range(0, 99));
         r_ld = (op < 6);
         r_st = (op >= 6 && op < 16) || (op == 99);
         r_ab = (op >= 16 && op < 19);
         r_en = ($urandom_range(0, 3) != 0);
         r_md = $urandom_range(0, 1) == 1;
         r_lv = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
         rst  = ($urandom_range(0, 127) == 0);
         step(r_ld, r_lv, r_st, r_ab, r_en, r_md);
         rst = 1'b0;
      end

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
